// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD countdown counter with per-digit
// borrow enables, a terminal-count done pulse and a load-rejected pulse.
// Optional build macro BCD_AUTORELOAD_EN: keep the last accepted nonzero load
// value and restart from it at terminal count instead of stopping at zero.
module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic [DIGITS-1:1]   ena,
  output logic                zero,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    dec_val;
  logic            done_q, done_d;
  logic            load_err_q, load_err_d;
`ifdef BCD_AUTORELOAD_EN
  logic [W-1:0]    reload_q, reload_d;
`endif

  logic [DIGITS-1:0] nib_ok;
  logic [DIGITS-1:0] nib_zero;
  // low_zero[i]: digits 0..i-1 are all zero (low_zero[0] is vacuously true)
  logic [DIGITS:0]   low_zero;
  logic              load_valid;
  logic              load_is_zero;
  logic              step;
  logic              terminal;

  assign low_zero[0] = 1'b1;

  // Per-digit validity, zero detect, borrow chain and decremented nibble
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur                = q_q[4*gi +: 4];
      assign nib_ok[gi]         = (load_val[4*gi +: 4] <= 4'd9);
      assign nib_zero[gi]       = (cur == 4'd0);
      assign low_zero[gi+1]     = low_zero[gi] & nib_zero[gi];
      // A digit steps only when every lower digit is zero; 0 borrows to 9
      assign dec_val[4*gi +: 4] = !low_zero[gi] ? cur :
                                  (nib_zero[gi] ? 4'd9 : cur - 4'd1);
    end

    for (gi = 1; gi < DIGITS; gi++) begin : g_ena
      assign ena[gi] = step & low_zero[gi];
    end
  endgenerate

  assign load_valid   = &nib_ok;
  assign load_is_zero = (load_val == '0);
  assign step         = (state_q == RUN) & en & ~load;
  assign terminal     = step & (q_q == ONE);

  // Next-state: load beats step; terminal count either stops or reloads
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef BCD_AUTORELOAD_EN
    reload_d   = reload_q;
`endif
    if (load) begin
      if (!load_valid) begin
        load_err_d = 1'b1;
      end else if (load_is_zero) begin
        q_d     = '0;
        state_d = IDLE;
`ifdef BCD_AUTORELOAD_EN
        reload_d = '0;
`endif
      end else begin
        q_d     = load_val;
        state_d = RUN;
`ifdef BCD_AUTORELOAD_EN
        reload_d = load_val;
`endif
      end
    end else if (terminal) begin
      done_d = 1'b1;
`ifdef BCD_AUTORELOAD_EN
      q_d     = reload_q;
      state_d = RUN;
`else
      q_d     = '0;
      state_d = IDLE;
`endif
    end else if (step) begin
      q_d = dec_val;
    end
  end

  // State, count and pulse registers; async reset clears everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      q_q        <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_AUTORELOAD_EN
      reload_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef BCD_AUTORELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign q        = q_q;
  assign zero     = low_zero[DIGITS];
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Testbench for bcd_down_counter (DIGITS=4): directed vectors with literal
// expectations plus a decimal-integer reference model checked every cycle.
module tb_bcd_down_counter;

`ifdef BCD_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic [15:0] q;
  logic [3:1]  ena;
  logic        zero;
  logic        done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  bcd_down_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .q        (q),
    .ena      (ena),
    .zero     (zero),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic bit is_bcd(input logic [15:0] v);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int pw = 1;
    for (int i = 0; i < 4; i++) begin
      r += int'(v[4*i +: 4]) * pw;
      pw *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int t = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit i borrows when the value below it (mod 10^i) is exactly zero
  function automatic logic [3:1] model_ena(input int val, input bit run, input bit e, input bit l);
    logic [3:1] r;
    int pw = 1;
    for (int i = 1; i < 4; i++) begin
      pw *= 10;
      r[i] = run & e & ~l & ((val % pw) == 0);
    end
    return r;
  endfunction

  int m_val;
  int m_reload;
  bit m_run;
  bit m_done;
  bit m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val    <= 0;
      m_reload <= 0;
      m_run    <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (load) begin
        if (!is_bcd(load_val)) begin
          m_err <= 1'b1;
        end else if (bcd2int(load_val) == 0) begin
          m_val    <= 0;
          m_run    <= 1'b0;
          m_reload <= 0;
        end else begin
          m_val    <= bcd2int(load_val);
          m_run    <= 1'b1;
          m_reload <= bcd2int(load_val);
        end
      end else if (m_run && en) begin
        if (m_val == 1) begin
          m_done <= 1'b1;
          if (AUTO) begin
            m_val <= m_reload;
          end else begin
            m_val <= 0;
            m_run <= 1'b0;
          end
        end else begin
          m_val <= m_val - 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_q", q, int2bcd(m_val));
      chk("model_zero", zero, (m_val == 0));
      chk("model_done", done, m_done);
      chk("model_load_err", load_err, m_err);
      chk("model_ena", ena, model_ena(m_val, m_run, en, load));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit l, input logic [15:0] v, input bit e);
    load     = l;
    load_val = v;
    en       = e;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q_na   [7] = '{16'h2, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] q_auto [7] = '{16'h2, 16'h1, 16'h3, 16'h2, 16'h1, 16'h3, 16'h2};
  bit          d_na   [7] = '{0, 0, 1, 0, 0, 0, 0};
  bit          d_auto [7] = '{0, 0, 1, 0, 0, 1, 0};

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    load_val = 16'h0;
    en       = 1'b0;
    #2;
    chk("reset_q", q, 16'h0000);
    chk("reset_zero", zero, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_load_err", load_err, 1'b0);
    #10;
    reset = 1'b0;

    // Count 12 down to 0 with en held
    drive(1'b1, 16'h0012, 1'b0);
    chk("load12_q", q, 16'h0012);
    for (int i = 11; i >= 0; i--) begin
      load = 1'b0;
      en   = 1'b1;
      #1;
      chk("cnt12_ena", ena, (i + 1 == 10) ? 3'b001 : 3'b000);
      @(posedge clk);
      #1;
      if (i > 0)
        chk("cnt12_q", q, {8'h00, 4'(i / 10), 4'(i % 10)});
      else
        chk("cnt12_term_q", q, AUTO ? 16'h0012 : 16'h0000);
      chk("cnt12_done", done, (i == 0));
    end
    drive(1'b0, 16'h0, 1'b1);
    chk("after_term_q", q, AUTO ? 16'h0011 : 16'h0000);
    chk("after_term_done", done, 1'b0);
    drive(1'b1, 16'h0000, 1'b0);
    chk("zero_load_q", q, 16'h0000);
    chk("zero_load_zero", zero, 1'b1);

    // Borrow ripple across three digits
    drive(1'b1, 16'h1000, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    #1;
    chk("ripple_ena", ena, 3'b111);
    @(posedge clk);
    #1;
    chk("ripple_q", q, 16'h0999);

    // Invalid load is rejected
    drive(1'b1, 16'h0042, 1'b0);
    drive(1'b1, 16'h00A5, 1'b1);
    chk("bad_load_q", q, 16'h0042);
    chk("bad_load_err", load_err, 1'b1);
    chk("bad_load_done", done, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk("bad_load_err_clear", load_err, 1'b0);
    chk("bad_load_q_hold", q, 16'h0042);

    // Load wins over a terminal-count step in the same cycle
    drive(1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'h0300, 1'b1);
    chk("prio_q", q, 16'h0300);
    chk("prio_done", done, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    chk("prio_run_q", q, 16'h0299);
    drive(1'b1, 16'h0000, 1'b0);

    // Short count: stop at zero, or reload periodically
    drive(1'b1, 16'h0003, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 16'h0, 1'b1);
      chk("reload_q", q, AUTO ? q_auto[k] : q_na[k]);
      chk("reload_done", done, AUTO ? d_auto[k] : d_na[k]);
    end
    drive(1'b1, 16'h0000, 1'b0);

    // Asynchronous reset mid-count
    drive(1'b1, 16'h0500, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    chk("pre_reset_q", q, 16'h0499);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_q", q, 16'h0000);
    chk("async_reset_zero", zero, 1'b1);
    chk("async_reset_done", done, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    drive(1'b0, 16'h0, 1'b1);
    chk("idle_no_wrap_q", q, 16'h0000);
    drive(1'b0, 16'h0, 1'b0);

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
